// File: rtl/ahb_arbiter_gen2.sv
// AHB slave-port arbiter: fixed, round-robin or dynamic priority.
// Tracks burst beats, honours HLOCK and caps undefined INCR bursts.
module ahb_arbiter_gen2 #(
  parameter int MASTER_NUM = 4,
  parameter int PRIOR_BIT  = 2,
  parameter int ARB_MODE   = 0,
  parameter int INCR_MAX   = 16,
  parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic                            hclk,
  input  logic                            hreset_n,
  input  logic [MASTER_NUM-1:0]           hreq,
  input  logic [MASTER_NUM-1:0]           hlock,
  input  logic [MASTER_NUM*PRIOR_BIT-1:0] hprior,
  input  logic [1:0]                      htrans,
  input  logic [2:0]                      hburst,
  input  logic                            hready,
  output logic [MASTER_NUM-1:0]           hgrant,
  output logic                            hsel,
  output logic [MIDX_W-1:0]               hmaster,
  output logic                            hmastlock,
  output logic                            hlast_beat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANTED,
    S_BURST
  } state_t;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  state_t                 state, state_nxt;
  logic [MASTER_NUM-1:0]  grant_q, grant_nxt;
  logic [MIDX_W-1:0]      midx_q, midx_nxt;
  logic [MIDX_W-1:0]      rr_ptr, rr_nxt;
  logic [MIDX_W-1:0]      win, base;
  logic                   win_vld;
  logic [PRIOR_BIT-1:0]   best, pr;
  logic [8:0]             cnt, cnt_nxt, lim;
  logic                   acc, rel;

  // While a tenure is active the current owner counts as last winner
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    best    = '0;
    pr      = '0;
    base    = hsel ? midx_q : rr_ptr;
    if (ARB_MODE == 1) begin
      for (int k = 1; k <= MASTER_NUM; k++) begin
        for (int i = 0; i < MASTER_NUM; i++) begin
          if (!win_vld && hreq[i] &&
              i == (int'(base) + k) % MASTER_NUM) begin
            win_vld = 1'b1;
            win     = MIDX_W'(i);
          end
        end
      end
    end else if (ARB_MODE == 2) begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        pr = hprior[i*PRIOR_BIT +: PRIOR_BIT];
        if (hreq[i] && (!win_vld || pr > best)) begin
          win_vld = 1'b1;
          win     = MIDX_W'(i);
          best    = pr;
        end
      end
    end else begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (!win_vld && hreq[i]) begin
          win_vld = 1'b1;
          win     = MIDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    lim = 9'd16;
    unique case (hburst)
      3'd0:       lim = 9'd1;
      3'd1:       lim = 9'(INCR_MAX);
      3'd2, 3'd3: lim = 9'd4;
      3'd4, 3'd5: lim = 9'd8;
      default:    lim = 9'd16;
    endcase
  end

  assign acc = hsel & hready & htrans[1];

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    midx_nxt  = midx_q;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    rel       = 1'b0;
    if (hready) begin
      unique case (state)
        S_IDLE: begin
          if (win_vld) begin
            grant_nxt = MASTER_NUM'(1) << win;
            midx_nxt  = win;
            state_nxt = S_GRANTED;
          end
        end
        S_GRANTED: begin
          if (acc && htrans == T_NONSEQ) begin
            cnt_nxt = 9'd1;
            if (lim == 9'd1) rel = 1'b1;
            else state_nxt = S_BURST;
          end else if (htrans == T_IDLE && !hreq[midx_q]) begin
            rel = 1'b1;
          end
        end
        S_BURST: begin
          if (acc && htrans == T_SEQ) cnt_nxt = cnt + 9'd1;
          else if (acc) cnt_nxt = 9'd1;
          if (acc && cnt_nxt == lim) rel = 1'b1;
          else if (htrans == T_IDLE) rel = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
      // A locked owner keeps the bus; only its beat count restarts
      if (rel) begin
        cnt_nxt   = '0;
        state_nxt = S_GRANTED;
        if (!hlock[midx_q]) begin
          rr_nxt    = midx_q;
          grant_nxt = '0;
          if (win_vld) begin
            grant_nxt = MASTER_NUM'(1) << win;
            midx_nxt  = win;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state   <= S_IDLE;
      grant_q <= '0;
      midx_q  <= '0;
      rr_ptr  <= MIDX_W'(MASTER_NUM - 1);
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      midx_q  <= midx_nxt;
      rr_ptr  <= rr_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign hgrant     = grant_q & {MASTER_NUM{hready}};
  assign hsel       = |grant_q;
  assign hmaster    = midx_q;
  assign hmastlock  = |(grant_q & hlock);
  assign hlast_beat = rel;

endmodule

// File: tb/tb_ahb_arbiter_gen2.sv
// Directed bench for ahb_arbiter_gen2 in all three arbitration modes.
// Inputs are shared; each scenario checks the instance it targets.
module tb_ahb_arbiter_gen2;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [3:0] hreq, hlock;
  logic [7:0] hprior;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;

  logic [3:0] g0, g1, g2;
  logic       s0, s1, s2;
  logic [1:0] m0, m1, m2;
  logic       ml0, ml1, ml2;
  logic       lb0, lb1, lb2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter_gen2 #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(0),
                     .INCR_MAX(4)) u0 (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock),
    .hprior(hprior), .htrans(htrans), .hburst(hburst),
    .hready(hready), .hgrant(g0), .hsel(s0), .hmaster(m0),
    .hmastlock(ml0), .hlast_beat(lb0));

  ahb_arbiter_gen2 #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(1),
                     .INCR_MAX(16)) u1 (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock),
    .hprior(hprior), .htrans(htrans), .hburst(hburst),
    .hready(hready), .hgrant(g1), .hsel(s1), .hmaster(m1),
    .hmastlock(ml1), .hlast_beat(lb1));

  ahb_arbiter_gen2 #(.MASTER_NUM(4), .PRIOR_BIT(2), .ARB_MODE(2),
                     .INCR_MAX(16)) u2 (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hlock(hlock),
    .hprior(hprior), .htrans(htrans), .hburst(hburst),
    .hready(hready), .hgrant(g2), .hsel(s2), .hmaster(m2),
    .hmastlock(ml2), .hlast_beat(lb2));

  task automatic step;
    @(posedge hclk);
    #1;
  endtask

  task automatic clr_inputs;
    hreq   = '0;
    hlock  = '0;
    hprior = '0;
    htrans = 2'd0;
    hburst = 3'd0;
    hready = 1'b1;
  endtask

  task automatic do_reset;
    hreset_n = 1'b0;
    clr_inputs();
    @(negedge hclk);
    hreset_n = 1'b1;
  endtask

  task automatic test_reset;
    hreset_n = 1'b0;
    clr_inputs();
    #12;
    n_cmp++;
    if (g0 !== 4'b0) begin
      n_bad++; $display("FAIL rst_hgrant got %b want 0000", g0);
    end
    n_cmp++;
    if (s0 !== 1'b0) begin
      n_bad++; $display("FAIL rst_hsel got %b want 0", s0);
    end
    n_cmp++;
    if (m0 !== 2'd0) begin
      n_bad++; $display("FAIL rst_hmaster got %0d want 0", m0);
    end
    n_cmp++;
    if (ml0 !== 1'b0 || lb0 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_lock_last got %b%b want 00", ml0, lb0);
    end
    @(negedge hclk);
    hreset_n = 1'b1;
  endtask

  task automatic test_fixed;
    do_reset();
    hreq = 4'b1010;
    step();
    n_cmp++;
    if (m0 !== 2'd1 || s0 !== 1'b1 || g0 !== 4'b0010) begin
      n_bad++;
      $display("FAIL fix_grant got m=%0d s=%b g=%b want m=1 s=1 g=0010",
               m0, s0, g0);
    end
    htrans = 2'd2;
    hburst = 3'd0;
    hreq   = 4'b1000;
    #2;
    n_cmp++;
    if (lb0 !== 1'b1) begin
      n_bad++; $display("FAIL fix_last got %b want 1", lb0);
    end
    step();
    htrans = 2'd0;
    n_cmp++;
    if (m0 !== 2'd3 || g0 !== 4'b1000) begin
      n_bad++;
      $display("FAIL fix_handover got m=%0d g=%b want m=3 g=1000",
               m0, g0);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_m [5];
    exp_m = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    hreq = 4'b1111;
    step();
    n_cmp++;
    if (m1 !== exp_m[0]) begin
      n_bad++; $display("FAIL rr_first got %0d want %0d", m1, exp_m[0]);
    end
    htrans = 2'd2;
    hburst = 3'd0;
    for (int k = 0; k < 4; k++) begin
      #2;
      n_cmp++;
      if (lb1 !== 1'b1) begin
        n_bad++; $display("FAIL rr_last[%0d] got %b want 1", k, lb1);
      end
      step();
      n_cmp++;
      if (m1 !== exp_m[k+1]) begin
        n_bad++;
        $display("FAIL rr_order[%0d] got %0d want %0d",
                 k, m1, exp_m[k+1]);
      end
    end
    htrans = 2'd0;
  endtask

  task automatic test_dynamic;
    logic [1:0] tr  [6];
    logic       rdy [6];
    logic       lb  [6];
    tr  = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    lb  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    hprior = {2'd3, 2'd1, 2'd3, 2'd0};
    hreq   = 4'b1111;
    step();
    n_cmp++;
    if (m2 !== 2'd1) begin
      n_bad++; $display("FAIL dyn_tie got %0d want 1", m2);
    end
    hburst = 3'd3;
    for (int k = 0; k < 6; k++) begin
      htrans = tr[k];
      hready = rdy[k];
      if (k == 5) hreq = 4'b1101;
      #2;
      n_cmp++;
      if (lb2 !== lb[k]) begin
        n_bad++;
        $display("FAIL dyn_last[%0d] got %b want %b", k, lb2, lb[k]);
      end
      if (!rdy[k]) begin
        n_cmp++;
        if (g2 !== 4'b0000) begin
          n_bad++;
          $display("FAIL dyn_wait_gnt[%0d] got %b want 0000", k, g2);
        end
      end
      step();
    end
    htrans = 2'd0;
    hready = 1'b1;
    n_cmp++;
    if (m2 !== 2'd3) begin
      n_bad++; $display("FAIL dyn_next got %0d want 3", m2);
    end
  endtask

  task automatic test_incr_limit;
    logic [1:0] tr [4];
    logic       lb [4];
    tr = '{2'd2, 2'd3, 2'd3, 2'd3};
    lb = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int lk = 0; lk < 2; lk++) begin
      do_reset();
      hlock = (lk == 1) ? 4'b0100 : 4'b0000;
      hreq  = 4'b0100;
      step();
      n_cmp++;
      if (m0 !== 2'd2 || ml0 !== lk[0]) begin
        n_bad++;
        $display("FAIL incr_grant[%0d] got m=%0d lk=%b want m=2 lk=%b",
                 lk, m0, ml0, lk[0]);
      end
      hreq   = 4'b0101;
      hburst = 3'd1;
      for (int k = 0; k < 4; k++) begin
        htrans = tr[k];
        #2;
        n_cmp++;
        if (lb0 !== lb[k]) begin
          n_bad++;
          $display("FAIL incr_last[%0d][%0d] got %b want %b",
                   lk, k, lb0, lb[k]);
        end
        step();
      end
      n_cmp++;
      if (m0 !== (lk == 1 ? 2'd2 : 2'd0) || ml0 !== lk[0]) begin
        n_bad++;
        $display("FAIL incr_after[%0d] got m=%0d lk=%b want m=%0d lk=%b",
                 lk, m0, ml0, (lk == 1 ? 2 : 0), lk[0]);
      end
      htrans = 2'd2;
      #2;
      n_cmp++;
      if (lb0 !== 1'b0) begin
        n_bad++; $display("FAIL incr_restart[%0d] got %b want 0", lk, lb0);
      end
      step();
      htrans = 2'd0;
    end
    hlock = '0;
  endtask

  task automatic test_early_term;
    do_reset();
    hreq = 4'b0010;
    step();
    n_cmp++;
    if (m0 !== 2'd1) begin
      n_bad++; $display("FAIL et_grant got %0d want 1", m0);
    end
    hreq   = 4'b0011;
    hburst = 3'd5;
    for (int k = 0; k < 4; k++) begin
      htrans = (k == 0) ? 2'd2 : (k == 3) ? 2'd0 : 2'd3;
      #2;
      n_cmp++;
      if (lb0 !== (k == 3)) begin
        n_bad++;
        $display("FAIL et_last[%0d] got %b want %b", k, lb0, (k == 3));
      end
      step();
    end
    n_cmp++;
    if (m0 !== 2'd0 || s0 !== 1'b1) begin
      n_bad++; $display("FAIL et_rearb got m=%0d s=%b want m=0 s=1", m0, s0);
    end
    for (int k = 0; k < 4; k++) begin
      htrans = (k == 0) ? 2'd2 : 2'd3;
      step();
    end
    htrans = 2'd3;
    #2;
    n_cmp++;
    if (s0 !== 1'b1 || lb0 !== 1'b0) begin
      n_bad++;
      $display("FAIL et_beat5 got s=%b lb=%b want s=1 lb=0", s0, lb0);
    end
    hreset_n = 1'b0;
    #1;
    n_cmp++;
    if (s0 !== 1'b0 || g0 !== 4'b0000) begin
      n_bad++;
      $display("FAIL et_async_rst got s=%b g=%b want s=0 g=0000", s0, g0);
    end
    @(negedge hclk);
    clr_inputs();
    hreset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_dynamic();
    test_incr_limit();
    test_early_term();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_gen2.md
# ahb_arbiter_gen2

Parametrised AHB bus arbiter for one slave port of the generated interconnect. Successor to the per-slave arbiter. Arbitration mode is selected by parameter: fixed priority, round-robin or dynamic priority. It adds HLOCK support, per-transfer HTRANS tracking, early-termination detection, and a forced re-arbitration limit for undefined-length INCR bursts. Sits between the master-side request lines and the slave-side address/data mux select.

## Interface
- MASTER_NUM, 4, number of requesting masters (2..16)
- PRIOR_BIT, 2, width of each dynamic priority field
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin, 2 = dynamic priority
- INCR_MAX, 16, beat limit for HBURST = INCR before forced release (1..256)
- MIDX_W, $clog2(MASTER_NUM), master index width (derived)

- hclk  in  1  bus clock
- hreset_n  in  1  reset; asynchronous, active-low
- hreq  in  MASTER_NUM  bus request, one bit per master
- hlock  in  MASTER_NUM  locked-transfer request, one bit per master
- hprior  in  MASTER_NUM*PRIOR_BIT  dynamic priority; field i = bits [i*PRIOR_BIT +: PRIOR_BIT]; ignored unless ARB_MODE = 2
- htrans  in  2  HTRANS of the currently granted master (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- hburst  in  3  HBURST of the currently granted master (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
- hready  in  1  slave ready; low = wait state
- hgrant  out  MASTER_NUM  grant_q & {MASTER_NUM{hready}}
- hsel  out  1  |grant_q; slave select
- hmaster  out  MIDX_W  index of the granted master; holds its last value when no master is granted
- hmastlock  out  1  |(grant_q & hlock)
- hlast_beat  out  1  pulse: the accepted beat ends the current tenure

## Operation
- Registered state: grant_q (one-hot or zero), state, beat count cnt (9 bits), rr_ptr (last winner index).
- Winner (combinational, over hreq):
  - ARB_MODE 0: lowest index wins.
  - ARB_MODE 1: first requester at index rr_ptr+1, rr_ptr+2, … (modulo MASTER_NUM).
  - ARB_MODE 2: highest hprior wins; ties go to the lowest index.
- Beat limit L from hburst: SINGLE 1, INCR INCR_MAX, WRAP4/INCR4 4, WRAP8/INCR8 8, WRAP16/INCR16 16.
- Accepted beat = hsel & hready & htrans ∈ {NONSEQ, SEQ}.
- Release condition, evaluated only when hready = 1:
  - (a) accepted beat with cnt_next == L, or
  - (b) htrans == IDLE in BURST state, or
  - (c) htrans == IDLE in GRANTED state with hreq[hmaster] == 0.
- On release:
  - hlast_beat = 1.
  - If hlock[hmaster] = 1: grant is kept, cnt <= 0, state <= GRANTED.
  - Otherwise: grant_q <= winner, rr_ptr <= hmaster, cnt <= 0, state <= GRANTED, or IDLE if no hreq.
- FSM:
  - IDLE: grant_q = 0. Any hreq -> load winner, go to GRANTED.
  - GRANTED: NONSEQ accepted -> cnt <= 1; release if L == 1, else go to BURST. Release condition (c) -> release.
  - BURST:
    - SEQ accepted -> cnt++.
    - NONSEQ accepted -> new burst, cnt <= 1.
    - BUSY -> hold.
    - Release per (a)/(b).
- hready = 0 freezes cnt, state, grant_q and rr_ptr.
- Dropping hreq mid-burst does not shorten the burst.

## Timing
- Reset values: grant_q = 0, hgrant = 0, hsel = 0, hmaster = 0, hmastlock = 0, hlast_beat = 0, state = IDLE, cnt = 0, rr_ptr = MASTER_NUM-1 (master 0 is first in round-robin).
- Grant latency: hreq sampled in IDLE at edge N -> hsel/hmaster valid after edge N; hgrant valid after edge N when hready = 1.
- Handover: the release beat and the new grant_q take effect on the same edge. No dead cycle when another master is requesting.
- hlast_beat is combinational, valid in the release cycle only.
- Locked INCR reaching INCR_MAX: the lock wins, the grant is held and the count restarts.
- Reset asserted mid-burst: all state clears immediately and asynchronously.

## Test plan
- Mode 0, hreq = 4'b1010 from IDLE -> hmaster = 1 one cycle later. Master 1 issues SINGLE NONSEQ with hready = 1 -> hlast_beat pulse, next hmaster = 3.
- Mode 1, hreq = 4'b1111 held, every master issues SINGLE -> grant order 0,1,2,3,0.
- Mode 2, hprior = {3,1,3,0} (master3..0), hreq = 4'b1111 -> master 1 wins (ties go to lowest index). Master 1 INCR4 with 2 wait states mid-burst -> exactly 4 accepted beats before release.
- INCR_MAX = 4, master 2 INCR unlocked with continuous SEQ, master 0 requesting -> release after beat 4, hmaster = 0. Repeat with hlock[2] = 1 -> master 2 retains grant, hmastlock = 1.
- INCR8 early termination: htrans = IDLE after beat 3 -> hlast_beat, re-arbitration. Assert hreset_n low at beat 5 of a second burst -> hsel = 0, hgrant = 0 immediately.
